dds_wave_gen: RTL and testbench
===============================

// Module: dds_wave_gen
// PURPOSE
//  Direct-digital waveform generator for the dual DAC path (channels A/B). A 16-bit phase
//  accumulator advances on a sample tick made by an internal clock divider; phase[15:7]
//  indexes a 512-point sine or square lookup. Result is registered onto both DAC buses.
//  Sits between the mode/key control logic and the DAC pins; replaces a PLL with a clock enable.
// PARAMETERS
//  CLK_DIV   1   sample tick every CLK_DIV clk cycles (>=1); 1 = tick every cycle
// PORTS
//  clk        in   1   single system clock; all logic on posedge
//  rst        in   1   reset, asynchronous, active-high
//  freq_word  in   16  phase increment per tick (output freq = f_tick*freq_word/65536)
//  wave_sel   in   2   0=sine, 1=square, 2/3=mid-scale DC (8192)
//  sample_tick out 1   one-clk pulse marking each sample update
//  da_a       out  14  DAC A code, offset binary, registered
//  da_b       out  14  DAC B code, identical to da_a
// BEHAVIOUR
//  Reset (async assert): phase=0, div counter=0, sample_tick=0, da_a=da_b=14'd8192.
//  Divider: cnt counts 0..CLK_DIV-1 and wraps; tick is combinational cnt==CLK_DIV-1;
//   sample_tick output is tick registered (so it is high the cycle da_* changes).
//  On each tick edge (same edge): phase <= phase + freq_word (mod 2^16, wrap silent);
//   da_a/da_b <= table(phase[15:7]) using the PRE-update phase; latency 1 tick.
//  No tick: phase, da_* hold. freq_word=0 -> output constant at table(phase[15:7]).
//  freq_word / wave_sel sampled at tick edge only; changes between ticks take effect next tick.
//  Sine index i (0..511), q=i[8:7], j=i[6:0], Q[k]=round(8191*sin(2*pi*k/512)), k=0..128:
//   q0: 8192+Q[j]  q1: 8192+Q[128-j]  q2: 8192-Q[j]  q3: 8192-Q[128-j]
//   Range 1..16383; i=0 ->8192, 64 ->13984, 128 ->16383, 256 ->8192, 384 ->1.
//  Square: i[8]==0 -> 16383, i[8]==1 -> 0 (50% duty, high first half of cycle).
//  wave_sel 2/3: 8192 regardless of phase (phase still advances).
//  Reset mid-operation: immediate return to reset values; first tick after release
//   outputs table(0) (sine 8192 / square 16383).
//  All table math purely combinational from constants; no multipliers, no memories with init files.
// STRUCTURE
//  Package dds_pkg: PHASE_W=16, IDX_W=9, DAC_W=14, MID=14'd8192, FULL=14'd16383,
//   wave_sel encodings (WAVE_SINE, WAVE_SQUARE).
//  Sub-module sin_quarter_rom: 8-bit addr k (0..128) -> 13-bit Q[k], combinational case table.
//  Top holds divider, accumulator, quadrant fold/negate, square logic, output mux/register.
// TESTING
//  1 Reset: hold rst, toggle clk -> da_a=da_b=8192, sample_tick=0; release, no tick yet -> hold.
//  2 CLK_DIV=1, sine, freq_word=16384 -> da_a sequence 8192,16383,8192,1,8192,... per clk.
//  3 CLK_DIV=1, sine, freq_word=8192 -> 8192,13984,16383,13984,8192,2400,1,2400, repeat.
//  4 Square, freq_word=16384 -> 16383,16383,0,0 repeating; da_b==da_a every cycle.
//  5 CLK_DIV=4, freq_word=16384 -> sample_tick every 4th clk, da_a changes only with it.
//  6 Sine freq_word=2621 full sweep: compare every output to formula; assert rst mid-run
//   -> immediate 8192, phase restarts at 0; wave_sel=2 -> constant 8192.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths, DAC code constants and waveform encodings for dds_wave_gen
package dds_pkg;

    localparam int PHASE_W = 16;
    localparam int IDX_W   = 9;
    localparam int DAC_W   = 14;

    localparam logic [DAC_W-1:0] MID  = 14'd8192;
    localparam logic [DAC_W-1:0] FULL = 14'd16383;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_DC     = 2'd2,
        WAVE_DC_ALT = 2'd3
    } wave_e;

endpackage

// File: rtl/sin_quarter_rom.sv
// rtl/sin_quarter_rom.sv - quarter-wave sine magnitude table, Q[k]=round(8191*sin(2*pi*k/512)), k=0..128
module sin_quarter_rom (
    input  logic [7:0]  addr,
    output logic [12:0] q
);

    localparam longint ONE  = 64'sd1073741824;
    localparam longint PI_F = 64'sd3373259426;

    // Fixed-point Taylor series, evaluated only at elaboration to fill the constant table.
    function automatic logic [12:0] quarter_sine(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        x    = longint'(k) * PI_F / 64'sd256;
        x2   = x * x / ONE;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(term * x2 / ONE) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = (sum * 64'sd8191 + ONE / 64'sd2) / ONE;
        return 13'(r);
    endfunction

    logic [12:0] tab [0:128];

    for (genvar k = 0; k <= 128; k++) begin : g_tab
        localparam logic [12:0] V = quarter_sine(k);
        assign tab[k] = V;
    end

    always_comb begin
        q = '0;
        if (addr <= 8'd128) begin
            q = tab[addr];
        end
    end

endmodule

// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - clock-enabled DDS: divider, phase accumulator, sine/square/DC lookup, dual DAC register
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    output logic               sample_tick,
    output logic [DAC_W-1:0]   da_a,
    output logic [DAC_W-1:0]   da_b
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         rom_addr;
    logic [12:0]        q_val;
    logic [DAC_W-1:0]   sine_val;
    logic [DAC_W-1:0]   square_val;
    logic [DAC_W-1:0]   wave_val;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    sin_quarter_rom u_rom (
        .addr (rom_addr),
        .q    (q_val)
    );

    // Quadrants 1 and 3 read the quarter table mirrored; quadrants 2 and 3 subtract from mid-scale.
    always_comb begin
        idx        = phase[PHASE_W-1 -: IDX_W];
        rom_addr   = idx[7] ? (8'd128 - {1'b0, idx[6:0]}) : {1'b0, idx[6:0]};
        sine_val   = idx[8] ? (MID - {1'b0, q_val}) : (MID + {1'b0, q_val});
        square_val = idx[8] ? '0 : FULL;
        case (wave_e'(wave_sel))
            WAVE_SINE:   wave_val = sine_val;
            WAVE_SQUARE: wave_val = square_val;
            default:     wave_val = MID;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            phase       <= '0;
            sample_tick <= 1'b0;
            da_a        <= MID;
            da_b        <= MID;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            sample_tick <= tick;
            if (tick) begin
                phase <= phase + freq_word;
                da_a  <= wave_val;
                da_b  <= wave_val;
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - directed self-checking bench for dds_wave_gen (CLK_DIV=1 and CLK_DIV=4 instances)
module tb_dds_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] freq_word = 16'd0;
    logic [1:0]  wave_sel = 2'd0;
    logic        st1;
    logic        st4;
    logic [13:0] da_a1;
    logic [13:0] da_b1;
    logic [13:0] da_a4;
    logic [13:0] da_b4;

    int vectors     = 0;
    int miscompares = 0;

    int seq2 [4] = '{8192, 16383, 8192, 1};
    int seq3 [8] = '{8192, 13984, 16383, 13984, 8192, 2400, 1, 2400};
    int seq4 [4] = '{16383, 16383, 0, 0};

    always #5 clk = ~clk;

    dds_wave_gen #(.CLK_DIV(1)) u_div1 (
        .clk         (clk),
        .rst         (rst),
        .freq_word   (freq_word),
        .wave_sel    (wave_sel),
        .sample_tick (st1),
        .da_a        (da_a1),
        .da_b        (da_b1)
    );

    dds_wave_gen #(.CLK_DIV(4)) u_div4 (
        .clk         (clk),
        .rst         (rst),
        .freq_word   (freq_word),
        .wave_sel    (wave_sel),
        .sample_tick (st4),
        .da_a        (da_a4),
        .da_b        (da_b4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
    endtask

    function automatic int qtab(input int k);
        real v;
        v = 8191.0 * $sin(2.0 * 3.141592653589793 * k / 512.0);
        return $rtoi(v + 0.5);
    endfunction

    function automatic int sine_model(input int i);
        int q;
        int j;
        q = i / 128;
        j = i % 128;
        case (q)
            0:       return 8192 + qtab(j);
            1:       return 8192 + qtab(128 - j);
            2:       return 8192 - qtab(j);
            default: return 8192 - qtab(128 - j);
        endcase
    endfunction

    initial begin
        int mphase;
        int exp_v;
        int exp4;

        // reset state
        freq_word = 16'd16384;
        wave_sel  = 2'd0;
        rst       = 1'b1;
        repeat (3) clk_step();
        check("rst_da_a1", da_a1, 8192);
        check("rst_da_b1", da_b1, 8192);
        check("rst_st1",   st1,   0);
        check("rst_da_a4", da_a4, 8192);
        check("rst_st4",   st4,   0);
        rst = 1'b0;
        #3;
        check("hold_da_a1", da_a1, 8192);
        check("hold_st1",   st1,   0);

        // sine, quarter-cycle steps
        for (int n = 0; n < 8; n++) begin
            clk_step();
            check("sine16k_da_a", da_a1, seq2[n % 4]);
            check("sine16k_st",   st1,   1);
        end

        // sine, eighth-cycle steps
        freq_word = 16'd8192;
        restart();
        for (int n = 0; n < 16; n++) begin
            clk_step();
            check("sine8k_da_a", da_a1, seq3[n % 8]);
        end

        // square
        wave_sel  = 2'd1;
        freq_word = 16'd16384;
        restart();
        for (int n = 0; n < 8; n++) begin
            clk_step();
            check("square_da_a", da_a1, seq4[n % 4]);
            check("square_da_b", da_b1, seq4[n % 4]);
        end

        // divide-by-4 instance
        wave_sel  = 2'd0;
        freq_word = 16'd16384;
        restart();
        exp4 = 8192;
        for (int n = 1; n <= 16; n++) begin
            clk_step();
            if (n % 4 == 0) exp4 = seq2[(n / 4 - 1) % 4];
            check("div4_st",   st4,   (n % 4 == 0) ? 1 : 0);
            check("div4_da_a", da_a4, exp4);
            check("div4_da_b", da_b4, exp4);
        end

        // sweep against the formula
        freq_word = 16'd2621;
        restart();
        mphase = 0;
        for (int n = 0; n < 100; n++) begin
            clk_step();
            exp_v  = sine_model(mphase >> 7);
            mphase = (mphase + 2621) & 16'hFFFF;
            check("sweep_da_a", da_a1, exp_v);
            check("sweep_da_b", da_b1, exp_v);
        end

        // asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("midrst_da_a1", da_a1, 8192);
        check("midrst_da_b1", da_b1, 8192);
        check("midrst_st1",   st1,   0);
        check("midrst_da_a4", da_a4, 8192);
        clk_step();
        rst    = 1'b0;
        mphase = 0;
        for (int n = 0; n < 30; n++) begin
            clk_step();
            exp_v  = sine_model(mphase >> 7);
            mphase = (mphase + 2621) & 16'hFFFF;
            check("postrst_da_a", da_a1, exp_v);
        end

        // mid-scale DC while phase keeps advancing
        wave_sel = 2'd2;
        for (int n = 0; n < 10; n++) begin
            clk_step();
            mphase = (mphase + 2621) & 16'hFFFF;
            check("dc_da_a", da_a1, 8192);
        end
        wave_sel = 2'd0;
        for (int n = 0; n < 10; n++) begin
            clk_step();
            exp_v  = sine_model(mphase >> 7);
            mphase = (mphase + 2621) & 16'hFFFF;
            check("resume_da_a", da_a1, exp_v);
        end

        // zero increment freezes the output at the current phase
        freq_word = 16'd0;
        exp_v = sine_model(mphase >> 7);
        for (int n = 0; n < 5; n++) begin
            clk_step();
            check("freq0_da_a", da_a1, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
